display_ctrl: RTL and testbench

- Parametrised control front-end for the LED matrix display.
- Merges the debounced brightness button, the roll-mode switches and strobed UART command bytes into one registered control state: brightness level, PWM duty and roll mode.
- Ramps the PWM duty smoothly between levels (fade) instead of stepping.
- Sits between uart_receiver (command channel) and led_driver/pwm, replacing the inline brightness/roll glue in the top level.

---
 rtl/display_ctrl_pkg.sv | 39 +++
 rtl/display_ctrl_btn_debounce.sv | 62 ++++++
 rtl/display_ctrl.sv | 161 ++++++++++++++++
 tb/tb_display_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_ctrl_pkg.sv
// Shared definitions for the LED matrix display control front-end.
// Holds the UART command codes, the roll-mode encodings, the decoded
// command classes and the brightness-to-duty mapping function.
package display_ctrl_pkg;

  // UART command codes
  localparam logic [7:0] CMD_ROLL_BASE  = 8'h10;
  localparam logic [7:0] CMD_ROLL_REL   = 8'h1F;
  localparam logic [7:0] CMD_BRIGHT_SET = 8'h20;
  localparam logic [7:0] CMD_BRIGHT_UP  = 8'h30;
  localparam logic [7:0] CMD_BRIGHT_DN  = 8'h31;

  // Roll modes as understood by led_driver
  typedef enum logic [1:0] {
    ROLL_STATIC = 2'b00,
    ROLL_RIGHT  = 2'b01,
    ROLL_LEFT   = 2'b10,
    ROLL_RESET  = 2'b11
  } roll_mode_e;

  // Decoded meaning of the byte currently on cmd_data
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_ROLL_SET,
    CMD_ROLL_CLR,
    CMD_LVL_SET,
    CMD_LVL_BAD,
    CMD_LVL_UP,
    CMD_LVL_DN,
    CMD_ILLEGAL
  } cmd_kind_e;

  // Duty for level lvl: evenly spaced over full scale, top level = full scale.
  function automatic int unsigned duty_map(int unsigned lvl, int unsigned levels,
                                           int unsigned width);
    return ((lvl + 1) * ((32'd1 << width) - 1)) / levels;
  endfunction

endpackage

// File: rtl/display_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, invert (button is active-low),
// consecutive-cycle debounce counter and a one-cycle press pulse.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   btn_n       - raw asynchronous active-low button
//   press       - one-cycle pulse on the debounced released->pressed edge
module display_ctrl_btn_debounce #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  localparam int unsigned DB_RAW          = CLK_FREQ * DEBOUNCE_MS / 1000,
  localparam int unsigned DEBOUNCE_CYCLES = (DB_RAW == 0) ? 1 : DB_RAW,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             db_pressed;
  logic [CNT_W-1:0] cnt;
  logic             sync_pressed;

  assign sync_pressed = ~sync2;

  // Synchroniser resets to "released" so a button held through reset
  // must be seen stable for the full debounce time before it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // cnt holds how many consecutive cycles the synced input has disagreed
  // with the debounced state; the state flips on the last of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      db_pressed <= 1'b0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_pressed == db_pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt        <= '0;
        db_pressed <= sync_pressed;
        press      <= sync_pressed;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/display_ctrl.sv
// Control front-end for the LED matrix display. Merges the brightness
// button, roll switches and UART command bytes into a registered
// brightness level, a faded PWM duty and the roll mode.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   btn_bright_n          - raw active-low brightness button
//   roll_sw               - raw roll switches
//   cmd_data, cmd_valid   - command byte and its one-cycle strobe
//   bright_level          - current brightness level
//   duty_target           - duty mapped from bright_level
//   duty_out              - ramped duty for the PWM compare
//   fading                - duty_out has not yet reached duty_target
//   roll_mode             - roll mode to led_driver
//   cmd_err               - one-cycle pulse for an illegal command
module display_ctrl
  import display_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ         = 50_000_000,
  parameter int unsigned DEBOUNCE_MS      = 20,
  parameter int unsigned BRIGHT_LEVELS    = 4,
  parameter int unsigned DUTY_W           = 8,
  parameter int unsigned FADE_STEP_CYCLES = 50_000,
  localparam int unsigned LVL_W           = $clog2(BRIGHT_LEVELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_bright_n,
  input  logic [1:0]        roll_sw,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic [LVL_W-1:0]  bright_level,
  output logic [DUTY_W-1:0] duty_target,
  output logic [DUTY_W-1:0] duty_out,
  output logic              fading,
  output logic [1:0]        roll_mode,
  output logic              cmd_err
);

  localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(BRIGHT_LEVELS - 1);
  localparam logic [DUTY_W-1:0] DUTY0   = DUTY_W'(duty_map(0, BRIGHT_LEVELS, DUTY_W));
  localparam int unsigned       PRE_W   = $clog2(FADE_STEP_CYCLES > 2 ? FADE_STEP_CYCLES : 2);
  localparam logic [PRE_W-1:0]  PRE_LAST =
    PRE_W'(FADE_STEP_CYCLES > 0 ? FADE_STEP_CYCLES - 1 : 0);

  logic              press;
  logic [1:0]        roll_s1, roll_s2;
  logic              roll_ovr, roll_ovr_nxt;
  roll_mode_e        roll_cmd, roll_cmd_nxt;
  cmd_kind_e         kind;
  logic [LVL_W-1:0]  level_nxt;
  logic              err_nxt;
  logic [PRE_W-1:0]  presc;
  logic              tick;
  logic [DUTY_W-1:0] target_nxt, duty_nxt;
  logic              fading_nxt;

  display_ctrl_btn_debounce #(
    .CLK_FREQ    (CLK_FREQ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_bright_n),
    .press (press)
  );

  always_comb begin
    kind = CMD_NONE;
    if (cmd_valid) begin
      if (cmd_data >= CMD_ROLL_BASE && cmd_data <= CMD_ROLL_BASE + 8'd3)
        kind = CMD_ROLL_SET;
      else if (cmd_data == CMD_ROLL_REL)
        kind = CMD_ROLL_CLR;
      else if (cmd_data[7:4] == CMD_BRIGHT_SET[7:4])
        kind = (32'(cmd_data[3:0]) < BRIGHT_LEVELS) ? CMD_LVL_SET : CMD_LVL_BAD;
      else if (cmd_data == CMD_BRIGHT_UP)
        kind = CMD_LVL_UP;
      else if (cmd_data == CMD_BRIGHT_DN)
        kind = CMD_LVL_DN;
      else
        kind = CMD_ILLEGAL;
    end
  end

  // A press pulse owns the level this cycle; any brightness command
  // (including an out-of-range set) is dropped without an error.
  always_comb begin
    level_nxt    = bright_level;
    roll_ovr_nxt = roll_ovr;
    roll_cmd_nxt = roll_cmd;
    err_nxt      = (kind == CMD_ILLEGAL) || (kind == CMD_LVL_BAD && !press);
    if (press) begin
      level_nxt = (bright_level == LVL_MAX) ? '0 : bright_level + LVL_W'(1);
    end else begin
      case (kind)
        CMD_LVL_SET: level_nxt = cmd_data[LVL_W-1:0];
        CMD_LVL_UP:  if (bright_level != LVL_MAX) level_nxt = bright_level + LVL_W'(1);
        CMD_LVL_DN:  if (bright_level != '0) level_nxt = bright_level - LVL_W'(1);
        default: ;
      endcase
    end
    if (kind == CMD_ROLL_SET) begin
      roll_ovr_nxt = 1'b1;
      roll_cmd_nxt = roll_mode_e'(cmd_data[1:0]);
    end else if (kind == CMD_ROLL_CLR) begin
      roll_ovr_nxt = 1'b0;
    end
  end

  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      presc <= '0;
    else if (tick)
      presc <= '0;
    else
      presc <= presc + PRE_W'(1);
  end

  // The ramp always steps toward the current target, so a target change
  // mid-fade simply redirects it from wherever duty_out is.
  always_comb begin
    target_nxt = DUTY_W'(duty_map(32'(bright_level), BRIGHT_LEVELS, DUTY_W));
    duty_nxt   = duty_out;
    if (FADE_STEP_CYCLES == 0)
      duty_nxt = duty_target;
    else if (tick && duty_out < duty_target)
      duty_nxt = duty_out + DUTY_W'(1);
    else if (tick && duty_out > duty_target)
      duty_nxt = duty_out - DUTY_W'(1);
    fading_nxt = (FADE_STEP_CYCLES != 0) && (duty_nxt != target_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_level <= '0;
      duty_target  <= DUTY0;
      duty_out     <= DUTY0;
      fading       <= 1'b0;
      roll_mode    <= ROLL_STATIC;
      cmd_err      <= 1'b0;
      roll_ovr     <= 1'b0;
      roll_cmd     <= ROLL_STATIC;
      roll_s1      <= '0;
      roll_s2      <= '0;
    end else begin
      bright_level <= level_nxt;
      duty_target  <= target_nxt;
      duty_out     <= duty_nxt;
      fading       <= fading_nxt;
      cmd_err      <= err_nxt;
      roll_ovr     <= roll_ovr_nxt;
      roll_cmd     <= roll_cmd_nxt;
      roll_s1      <= roll_sw;
      roll_s2      <= roll_s1;
      roll_mode    <= roll_ovr_nxt ? roll_cmd_nxt : roll_s2;
    end
  end

endmodule

// File: tb/tb_display_ctrl.sv
// Self-checking bench for display_ctrl: directed scenarios followed by
// randomized stimulus, all compared each cycle against a behavioural model.
module tb_display_ctrl;

  localparam int LEVELS = 4;
  localparam int FSC    = 2;
  localparam int DB_N   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_bright_n = 1'b1;
  logic [1:0] roll_sw = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic [1:0] bright_level;
  logic [7:0] duty_target, duty_out;
  logic       fading;
  logic [1:0] roll_mode;
  logic       cmd_err;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  display_ctrl #(
    .CLK_FREQ         (1000),
    .DEBOUNCE_MS      (5),
    .BRIGHT_LEVELS    (LEVELS),
    .DUTY_W           (8),
    .FADE_STEP_CYCLES (FSC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_bright_n (btn_bright_n),
    .roll_sw      (roll_sw),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .bright_level (bright_level),
    .duty_target  (duty_target),
    .duty_out     (duty_out),
    .fading       (fading),
    .roll_mode    (roll_mode),
    .cmd_err      (cmd_err)
  );

  // Behavioural model state
  int m_level, m_target, m_out, m_presc, m_run;
  bit m_db, m_press, m_ovr, m_err;
  int m_rcmd, m_roll;
  bit m_btnPipe[2];
  int m_rollPipe[2];

  function automatic int dutyOf(int n);
    return ((n + 1) * 255) / LEVELS;
  endfunction

  task automatic checkOutput(string tag, int got, int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic modelReset();
    m_level = 0; m_target = dutyOf(0); m_out = dutyOf(0); m_presc = 0;
    m_run = 0; m_db = 0; m_press = 0; m_ovr = 0; m_err = 0;
    m_rcmd = 0; m_roll = 0;
    m_btnPipe[0] = 1; m_btnPipe[1] = 1;
    m_rollPipe[0] = 0; m_rollPipe[1] = 0;
  endtask

  // One clock edge of the reference behaviour, from the inputs present now.
  task automatic modelStep();
    int  nl;
    int  c;
    bit  syncPressed, pressNew, err;
    nl = m_level;
    err = 0;
    pressNew = 0;
    syncPressed = !m_btnPipe[1];
    if (syncPressed != m_db) begin
      m_run++;
      if (m_run == DB_N) begin
        m_db = syncPressed;
        m_run = 0;
        pressNew = syncPressed;
      end
    end else begin
      m_run = 0;
    end
    m_btnPipe[1] = m_btnPipe[0];
    m_btnPipe[0] = btn_bright_n;
    if (cmd_valid) begin
      c = int'(cmd_data);
      if (c >= 'h10 && c <= 'h13) begin m_ovr = 1; m_rcmd = c - 'h10; end
      else if (c == 'h1F) m_ovr = 0;
      else if (c >= 'h20 && c <= 'h2F) begin
        if (!m_press) begin
          if (c - 'h20 < LEVELS) nl = c - 'h20;
          else err = 1;
        end
      end
      else if (c == 'h30) begin if (!m_press && nl < LEVELS - 1) nl++; end
      else if (c == 'h31) begin if (!m_press && nl > 0) nl--; end
      else err = 1;
    end
    if (m_press) nl = (m_level + 1) % LEVELS;
    m_roll = m_ovr ? m_rcmd : m_rollPipe[1];
    m_rollPipe[1] = m_rollPipe[0];
    m_rollPipe[0] = int'(roll_sw);
    if (m_presc == FSC - 1) begin
      m_presc = 0;
      if (m_out < m_target) m_out++;
      else if (m_out > m_target) m_out--;
    end else begin
      m_presc++;
    end
    m_target = dutyOf(m_level);
    m_level = nl;
    m_press = pressNew;
    m_err = err;
  endtask

  task automatic compareAll();
    checkOutput("bright_level", int'(bright_level), m_level);
    checkOutput("duty_target", int'(duty_target), m_target);
    checkOutput("duty_out", int'(duty_out), m_out);
    checkOutput("fading", int'(fading), int'(m_out != m_target));
    checkOutput("roll_mode", int'(roll_mode), m_roll);
    checkOutput("cmd_err", int'(cmd_err), int'(m_err));
  endtask

  // Called at a falling edge: drive, clock once, then compare.
  task automatic applyStimulus(logic b, logic [1:0] r, logic v, logic [7:0] d);
    btn_bright_n = b;
    roll_sw = r;
    cmd_valid = v;
    cmd_data = d;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(int n);
    repeat (n) applyStimulus(btn_bright_n, roll_sw, 1'b0, 8'h00);
  endtask

  task automatic sendCmd(logic [7:0] d);
    applyStimulus(btn_bright_n, roll_sw, 1'b1, d);
  endtask

  task automatic pressBtn(int hold);
    repeat (hold) applyStimulus(1'b0, roll_sw, 1'b0, 8'h00);
    repeat (12) applyStimulus(1'b1, roll_sw, 1'b0, 8'h00);
  endtask

  initial begin
    bit sawFade;
    bit gotPulse;
    int holdLeft;
    bit btnVal;
    logic [1:0] rollVal;
    logic [7:0] codes [14];
    codes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h1F, 8'h20, 8'h21, 8'h22,
              8'h23, 8'h25, 8'h2F, 8'h30, 8'h31, 8'h00};

    // Reset state
    #1 rst_n = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_level", int'(bright_level), 0);
    checkOutput("rst_duty_out", int'(duty_out), 63);
    checkOutput("rst_duty_target", int'(duty_target), 63);
    checkOutput("rst_roll", int'(roll_mode), 0);
    checkOutput("rst_fading", int'(fading), 0);
    checkOutput("rst_err", int'(cmd_err), 0);
    rst_n = 1'b1;
    idle(3);

    // Short glitch then a clean long press with fade
    pressBtn(3);
    checkOutput("glitch_level", int'(bright_level), 0);
    sawFade = 0;
    repeat (10) applyStimulus(1'b0, roll_sw, 1'b0, 8'h00);
    repeat (20) begin
      applyStimulus(1'b1, roll_sw, 1'b0, 8'h00);
      if (fading) sawFade = 1;
    end
    checkOutput("press_level", int'(bright_level), 1);
    checkOutput("press_target", int'(duty_target), 127);
    checkOutput("fade_seen", int'(sawFade), 1);
    idle(150);
    checkOutput("fade_done_out", int'(duty_out), 127);
    checkOutput("fade_done_flag", int'(fading), 0);

    // Wrap sequence and saturating commands
    sendCmd(8'h23);
    pressBtn(8); checkOutput("wrap0", int'(bright_level), 0);
    pressBtn(8); checkOutput("wrap1", int'(bright_level), 1);
    pressBtn(8); checkOutput("wrap2", int'(bright_level), 2);
    pressBtn(8); checkOutput("wrap3", int'(bright_level), 3);
    sendCmd(8'h30); checkOutput("up_sat", int'(bright_level), 3);
    sendCmd(8'h20); checkOutput("set0", int'(bright_level), 0);
    sendCmd(8'h31); checkOutput("dn_sat", int'(bright_level), 0);

    // Level set, illegal codes, ignored data without valid
    sendCmd(8'h22); checkOutput("set2", int'(bright_level), 2);
    idle(1); checkOutput("set2_target", int'(duty_target), 191);
    sendCmd(8'h25); checkOutput("bad_set_err", int'(cmd_err), 1);
    checkOutput("bad_set_level", int'(bright_level), 2);
    idle(1); checkOutput("err_one_cycle", int'(cmd_err), 0);
    sendCmd(8'h77); checkOutput("illegal_err", int'(cmd_err), 1);
    applyStimulus(btn_bright_n, roll_sw, 1'b0, 8'h23);
    checkOutput("no_valid_level", int'(bright_level), 2);

    // Roll switches and override
    applyStimulus(btn_bright_n, 2'b01, 1'b0, 8'h00);
    idle(3); checkOutput("roll_sw01", int'(roll_mode), 1);
    sendCmd(8'h12); checkOutput("roll_ovr", int'(roll_mode), 2);
    for (int i = 0; i < 6; i++) applyStimulus(btn_bright_n, 2'(i), 1'b0, 8'h00);
    checkOutput("roll_ovr_hold", int'(roll_mode), 2);
    sendCmd(8'h1F);
    applyStimulus(btn_bright_n, 2'b11, 1'b0, 8'h00);
    idle(3); checkOutput("roll_release", int'(roll_mode), 3);

    // Press pulse and brightness command in the same cycle
    sendCmd(8'h21);
    gotPulse = 0;
    for (int i = 0; i < 20 && !gotPulse; i++) begin
      applyStimulus(1'b0, roll_sw, 1'b0, 8'h00);
      if (m_press) gotPulse = 1;
    end
    checkOutput("press_pulse_seen", int'(gotPulse), 1);
    applyStimulus(1'b0, roll_sw, 1'b1, 8'h23);
    checkOutput("collide_level", int'(bright_level), 2);
    checkOutput("collide_err", int'(cmd_err), 0);
    repeat (12) applyStimulus(1'b1, roll_sw, 1'b0, 8'h00);

    // Reset mid-fade, button held through reset release
    sendCmd(8'h23);
    idle(10);
    rst_n = 1'b0;
    btn_bright_n = 1'b0;
    #1;
    checkOutput("midfade_rst_out", int'(duty_out), 63);
    checkOutput("midfade_rst_level", int'(bright_level), 0);
    checkOutput("midfade_rst_fading", int'(fading), 0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) applyStimulus(1'b0, roll_sw, 1'b0, 8'h00);
    checkOutput("held_through_rst", int'(bright_level), 1);
    repeat (12) applyStimulus(1'b1, roll_sw, 1'b0, 8'h00);

    // Randomized phase
    holdLeft = 0;
    btnVal = 1;
    rollVal = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      logic       cv;
      logic [7:0] cd;
      int         pick;
      if (holdLeft == 0) begin
        btnVal = 1'($urandom_range(0, 1));
        holdLeft = $urandom_range(1, 12);
      end
      holdLeft--;
      if ($urandom_range(0, 19) == 0) rollVal = 2'($urandom_range(0, 3));
      cv = ($urandom_range(0, 5) == 0);
      pick = $urandom_range(0, 13);
      cd = (pick == 13) ? 8'($urandom_range(0, 255)) : codes[pick];
      applyStimulus(btnVal, rollVal, cv, cd);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
